// File: rtl/mac8_pkg.sv
// Shared constants and FSM state type for the mac8_frame_acc frame accumulator.
// Optional feature macro used by the top: MAC8_SATURATE_EN.
package mac8_pkg;

  localparam int PROD_W        = 16;
  localparam int FRAME_LEN_DEF = 8;
  localparam int ACC_W_DEF     = 24;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/mac8_frame_acc_vedic8x8.sv
// Combinational 8x8 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier built from 2x2 and 4x4 blocks.
// The overflow flag is the carry out of the final partial-product sum.
module vedic8x8
  import mac8_pkg::*;
(
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  output logic [PROD_W-1:0] product,
  output logic              overflow
);

  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] p;
    logic       c;
    p[0] = x[0] & y[0];
    p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c    = (x[1] & y[0]) & (x[0] & y[1]);
    p[2] = (x[1] & y[1]) ^ c;
    p[3] = (x[1] & y[1]) & c;
    return p;
  endfunction

  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    q0 = mul2(x[1:0], y[1:0]);
    q1 = mul2(x[3:2], y[1:0]);
    q2 = mul2(x[1:0], y[3:2]);
    q3 = mul2(x[3:2], y[3:2]);
    return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
  endfunction

  logic [7:0]  q0, q1, q2, q3;
  logic [16:0] sum;

  always_comb begin
    q0  = mul4(a[3:0], b[3:0]);
    q1  = mul4(a[7:4], b[3:0]);
    q2  = mul4(a[3:0], b[7:4]);
    q3  = mul4(a[7:4], b[7:4]);
    sum = {9'b0, q0} + {5'b0, q1, 4'b0} + {5'b0, q2, 4'b0} + {1'b0, q3, 8'b0};
  end

  assign product  = sum[PROD_W-1:0];
  assign overflow = sum[16];

endmodule

// File: rtl/mac8_frame_acc.sv
// Two-stage multiply-accumulate over frames of FRAME_LEN 8x8 products with a held result handshake.
// Define MAC8_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module mac8_frame_acc
  import mac8_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  if (FRAME_LEN < 2 || FRAME_LEN > 256) begin : g_bad_frame_len
    $error("mac8_frame_acc: FRAME_LEN=%0d outside 2..256", FRAME_LEN);
  end
  if (ACC_W < 17) begin : g_bad_acc_w
    $error("mac8_frame_acc: ACC_W=%0d below 17", ACC_W);
  end

  localparam int               CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic               pvld_q, pvld_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;

  logic [PROD_W-1:0]  mul_p;
  logic               mul_ovf_unused;
  logic               accept;
  logic [ACC_W:0]     sum_ext;
  logic               carry;

  vedic8x8 u_mul (
    .a        (a),
    .b        (b),
    .product  (mul_p),
    .overflow (mul_ovf_unused)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign accept    = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    pvld_d  = accept;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    if (accept) prod_d = mul_p;

    sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_q};
    carry   = sum_ext[ACC_W];

    if (pvld_q) begin
`ifdef MAC8_SATURATE_EN
      // Once clamped, the frame stays pinned at full scale.
      acc_d = (carry || ovf_q) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
      acc_d = sum_ext[ACC_W-1:0];
`endif
      ovf_d = ovf_q | carry;
    end

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: state_d = HOLD;
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          cnt_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      pvld_q  <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pvld_q  <= pvld_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: the product register is left unreset; pvld_q qualifies it, so stale data is never summed.
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
  end

endmodule

// File: tb/tb_mac8_frame_acc.sv
// Directed self-checking bench for mac8_frame_acc: default instance plus an ACC_W=17 instance.
// Expected values for the narrow instance follow MAC8_SATURATE_EN.
module tb_mac8_frame_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a, b;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_sum;
  logic        in_ready17, out_valid17, out_ovf17;
  logic [16:0] out_sum17;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mac8_frame_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  mac8_frame_acc #(.FRAME_LEN(8), .ACC_W(17)) dut17 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready17),
    .a         (a),
    .b         (b),
    .out_valid (out_valid17),
    .out_ready (out_ready),
    .out_sum   (out_sum17),
    .out_ovf   (out_ovf17)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beats(input int n, input logic [7:0] aa, input logic [7:0] bb);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      a        = aa;
      b        = bb;
      tick();
    end
    in_valid = 1'b0;
  endtask

  logic [23:0] held_sum;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum",   out_sum,   0);
    check("rst_out_ovf",   out_ovf,   0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // Scenario 1: 8 x (1*1), latency and sum
    beats(8, 8'd1, 8'd1);
    check("s1_drain_out_valid", out_valid, 0);
    check("s1_drain_in_ready",  in_ready,  0);
    tick();
    check("s1_out_valid", out_valid, 1);
    check("s1_out_sum",   out_sum,   8);
    check("s1_out_ovf",   out_ovf,   0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("s1_after_hs_out_valid", out_valid, 0);
    check("s1_after_hs_in_ready",  in_ready,  1);
    check("s1_after_hs_out_sum",   out_sum,   0);

    // Scenarios 2/3: 8 x (255*255) on both widths
    beats(8, 8'd255, 8'd255);
    tick();
    check("s2_out_valid", out_valid, 1);
    check("s2_out_sum",   out_sum,   520200);
    check("s2_out_ovf",   out_ovf,   0);
    check("s3_out_valid", out_valid17, 1);
`ifdef MAC8_SATURATE_EN
    check("s3_out_sum", out_sum17, 131071);
`else
    check("s3_out_sum", out_sum17, 126984);
`endif
    check("s3_out_ovf", out_ovf17, 1);

    // Scenario 4: consumer stalls for 5 cycles
    held_sum = out_sum;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s4_hold_out_sum",   out_sum,   held_sum);
      check("s4_hold_in_ready",  in_ready,  0);
      check("s4_hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("s4_after_hs_out_valid", out_valid, 0);
    check("s4_after_hs_in_ready",  in_ready,  1);
    check("s4_after_hs_out_ovf17", out_ovf17, 0);

    // Scenario 5: reset after 3 accepts with a product in flight, then gappy frame of 2*3
    beats(3, 8'd7, 8'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5_rst_out_sum",  out_sum,  0);
    check("s5_rst_in_ready", in_ready, 1);
    tick();
    check("s5_no_inflight_sum", out_sum, 0);
    for (int i = 0; i < 8; i++) begin
      beats(1, 8'd2, 8'd3);
      for (int g = 0; g < (i * 5 + 1) % 4; g++) tick();
    end
    for (int w = 0; w < 4 && !out_valid; w++) tick();
    check("s5_out_valid", out_valid, 1);
    check("s5_out_sum",   out_sum,   48);
    check("s5_out_ovf",   out_ovf,   0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Scenario 6: 9*5 held valid through DRAIN and HOLD
    in_valid = 1'b1;
    a        = 8'd9;
    b        = 8'd5;
    for (int i = 0; i < 8; i++) tick();
    check("s6_drain_in_ready", in_ready, 0);
    tick();
    check("s6_out_valid", out_valid, 1);
    tick();
    tick();
    check("s6_out_sum", out_sum, 360);
    check("s6_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("s6_after_hs_out_sum",  out_sum,  0);
    check("s6_after_hs_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) tick();
    in_valid = 1'b0;
    check("s6_f2_drain_out_valid", out_valid, 0);
    tick();
    check("s6_f2_out_valid", out_valid, 1);
    check("s6_f2_out_sum",   out_sum,   360);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("s6_f2_after_hs_out_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
